// File: rtl/pipeline_control_if.sv
// Control-unit bus between the pipelined datapath (master) and pipeline_control_unit (slave).
interface pipeline_control_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_OP_W   = 2
);
    logic                  id_valid;
    logic [6:0]            id_opcode;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  ex_flush;
    logic                  halt_req;

    logic                  stall;
    logic                  ex_alu_src;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic                  mem_mem_read;
    logic                  mem_mem_write;
    logic                  wb_reg_write;
    logic                  wb_mem_to_reg;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  halted;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_flush, halt_req,
        input  stall, ex_alu_src, ex_mem_read, ex_mem_write, ex_alu_op,
               mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_rd,
               forward_a, forward_b, halted
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_flush, halt_req,
        output stall, ex_alu_src, ex_mem_read, ex_mem_write, ex_alu_op,
               mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_rd,
               forward_a, forward_b, halted
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// Pipelined control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, hazard stall, flush and ECALL halt.
// FORWARDING_EN defined: forwarding muxes plus load-use stall; undefined: interlock-only RAW stalls.
module pipeline_control_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_OP_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    pipeline_control_if.slave  ctl
);
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef struct packed {
        logic                  valid;
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  halt;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  halt;
        logic [REG_ADDR_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  halt;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_t;

    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;
    id_ex_t  dec;
    logic    halt_pending;
    logic    halted;
    logic    hazard;
    logic    stall_c;
    logic    issue;

    logic is_load, is_store, is_arith, is_arith_imm, is_branch, is_jal, is_ecall;
    logic uses_rs1, uses_rs2;

    assign is_load      = (ctl.id_opcode == OP_LOAD);
    assign is_store     = (ctl.id_opcode == OP_STORE);
    assign is_arith     = (ctl.id_opcode == OP_ARITH);
    assign is_arith_imm = (ctl.id_opcode == OP_ARITH_IMM);
    assign is_branch    = (ctl.id_opcode == OP_BRANCH);
    assign is_jal       = (ctl.id_opcode == OP_JAL);
    assign is_ecall     = (ctl.id_opcode == OP_ECALL);
    assign uses_rs1     = !is_jal && !is_ecall;
    assign uses_rs2     = is_arith || is_store || is_branch;

    // ID-stage decode into the ID/EX payload
    always_comb begin
        dec            = '0;
        dec.valid      = 1'b1;
        dec.mem_read   = is_load;
        dec.mem_to_reg = is_load;
        dec.mem_write  = is_store;
        dec.alu_src    = !(is_arith || is_branch);
        dec.reg_write  = !(is_store || is_branch || is_ecall) && (ctl.id_rd != '0);
        dec.halt       = is_ecall && ctl.halt_req;
        dec.rd         = ctl.id_rd;
        if (is_branch)
            dec.alu_op = ALU_OP_W'(2'b01);
        else if (is_arith || is_arith_imm)
            dec.alu_op = ALU_OP_W'(2'b10);
    end

`ifdef FORWARDING_EN
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;

    // Only a load still in EX cannot be forwarded in time
    always_comb begin
        hazard = 1'b0;
        if (ctl.id_valid && id_ex.valid && id_ex.mem_read && (id_ex.rd != '0) &&
            ((uses_rs1 && (id_ex.rd == ctl.id_rs1)) || (uses_rs2 && (id_ex.rd == ctl.id_rs2))))
            hazard = 1'b1;
    end

    // EX/MEM result is younger, so it wins over MEM/WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (id_ex.valid) begin
            if (ex_mem.valid && ex_mem.reg_write && (ex_mem.rd != '0) && (ex_mem.rd == ex_rs1))
                fwd_a = 2'b10;
            else if (mem_wb.valid && mem_wb.reg_write && (mem_wb.rd != '0) && (mem_wb.rd == ex_rs1))
                fwd_a = 2'b01;
            if (ex_mem.valid && ex_mem.reg_write && (ex_mem.rd != '0) && (ex_mem.rd == ex_rs2))
                fwd_b = 2'b10;
            else if (mem_wb.valid && mem_wb.reg_write && (mem_wb.rd != '0) && (mem_wb.rd == ex_rs2))
                fwd_b = 2'b01;
        end
    end

    assign ctl.forward_a = fwd_a;
    assign ctl.forward_b = fwd_b;
`else
    // Interlock: wait until the producer reaches MEM/WB (regfile writes before it reads)
    always_comb begin
        hazard = 1'b0;
        if (ctl.id_valid) begin
            if (uses_rs1 && (ctl.id_rs1 != '0) &&
                ((id_ex.valid && id_ex.reg_write && (id_ex.rd == ctl.id_rs1)) ||
                 (ex_mem.valid && ex_mem.reg_write && (ex_mem.rd == ctl.id_rs1))))
                hazard = 1'b1;
            if (uses_rs2 && (ctl.id_rs2 != '0) &&
                ((id_ex.valid && id_ex.reg_write && (id_ex.rd == ctl.id_rs2)) ||
                 (ex_mem.valid && ex_mem.reg_write && (ex_mem.rd == ctl.id_rs2))))
                hazard = 1'b1;
        end
    end

    assign ctl.forward_a = 2'b00;
    assign ctl.forward_b = 2'b00;
`endif

    // A flush discards the ID instruction, so holding it would be pointless
    assign stall_c = !ctl.ex_flush && (hazard || halt_pending);
    assign issue   = ctl.id_valid && !stall_c && !ctl.ex_flush && !halt_pending && !halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex        <= '0;
            ex_mem       <= '0;
            mem_wb       <= '0;
            halt_pending <= 1'b0;
            halted       <= 1'b0;
`ifdef FORWARDING_EN
            ex_rs1       <= '0;
            ex_rs2       <= '0;
`endif
        end else begin
            id_ex             <= issue ? dec : '0;
            ex_mem.valid      <= id_ex.valid;
            ex_mem.mem_read   <= id_ex.mem_read;
            ex_mem.mem_write  <= id_ex.mem_write;
            ex_mem.reg_write  <= id_ex.reg_write;
            ex_mem.mem_to_reg <= id_ex.mem_to_reg;
            ex_mem.halt       <= id_ex.halt;
            ex_mem.rd         <= id_ex.rd;
            mem_wb.valid      <= ex_mem.valid;
            mem_wb.reg_write  <= ex_mem.reg_write;
            mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
            mem_wb.halt       <= ex_mem.halt;
            mem_wb.rd         <= ex_mem.rd;
            if (issue && dec.halt)
                halt_pending <= 1'b1;
            if (mem_wb.valid && mem_wb.halt)
                halted <= 1'b1;
`ifdef FORWARDING_EN
            ex_rs1 <= (issue && uses_rs1) ? ctl.id_rs1 : '0;
            ex_rs2 <= (issue && uses_rs2) ? ctl.id_rs2 : '0;
`endif
        end
    end

    assign ctl.stall         = stall_c;
    assign ctl.ex_alu_src    = id_ex.valid && id_ex.alu_src;
    assign ctl.ex_mem_read   = id_ex.valid && id_ex.mem_read;
    assign ctl.ex_mem_write  = id_ex.valid && id_ex.mem_write;
    assign ctl.ex_alu_op     = id_ex.valid ? id_ex.alu_op : '0;
    assign ctl.mem_mem_read  = ex_mem.valid && ex_mem.mem_read;
    assign ctl.mem_mem_write = ex_mem.valid && ex_mem.mem_write;
    assign ctl.wb_reg_write  = mem_wb.valid && mem_wb.reg_write;
    assign ctl.wb_mem_to_reg = mem_wb.valid && mem_wb.mem_to_reg;
    assign ctl.wb_rd         = mem_wb.valid ? mem_wb.rd : '0;
    assign ctl.halted        = halted;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit; expectations follow FORWARDING_EN when defined.
module tb_pipeline_control_unit;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipeline_control_if #(.REG_ADDR_W(5), .ALU_OP_W(2)) bus ();

    pipeline_control_unit #(.REG_ADDR_W(5), .ALU_OP_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "bench timeout");
    end

    function automatic logic [31:0] all_outs();
        return 32'({bus.stall, bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_op,
                    bus.mem_mem_read, bus.mem_mem_write, bus.wb_reg_write, bus.wb_mem_to_reg,
                    bus.wb_rd, bus.forward_a, bus.forward_b, bus.halted});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.ex_flush = 1'b0;
        bus.halt_req = 1'b0;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.ex_flush = 1'b0;
        bus.halt_req = 1'b0;
        set_id(1'b1, OP_ARITH, 5'd2, 5'd3, 5'd1);

        // 1: reset held two cycles with ADD x1,x2,x3 presented
        tick();
        check("reset_cyc1_outs", all_outs(), 32'd0);
        tick();
        check("reset_cyc2_outs", all_outs(), 32'd0);
        reset = 1'b0;
        #1;
        check("t1_c1_wb", 32'(bus.wb_reg_write), 32'd0);
        tick();
        check("t1_c2_wb", 32'(bus.wb_reg_write), 32'd0);
        check("t1_c2_alu_op", 32'(bus.ex_alu_op), 32'd2);
        tick();
        check("t1_c3_wb", 32'(bus.wb_reg_write), 32'd0);
        tick();
        check("t1_c4_wb", 32'(bus.wb_reg_write), 32'd1);
        check("t1_c4_wb_rd", 32'(bus.wb_rd), 32'd1);

        // 2: LW x5,0(x1) then ADD x6,x5,x1
        do_reset();
        set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
        check("t2_lw_stall", 32'(bus.stall), 32'd0);
        tick();
        set_id(1'b1, OP_ARITH, 5'd5, 5'd1, 5'd6);
        check("t2_stall1", 32'(bus.stall), 32'd1);
        check("t2_ex_mem_read", 32'(bus.ex_mem_read), 32'd1);
        tick();
        check("t2_bubble_mem_read", 32'(bus.ex_mem_read), 32'd0);
`ifdef FORWARDING_EN
        check("t2_stall2", 32'(bus.stall), 32'd0);
        tick();
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("t2_fwd_a", 32'(bus.forward_a), 32'd1);
        check("t2_fwd_b", 32'(bus.forward_b), 32'd0);
`else
        check("t2_stall2", 32'(bus.stall), 32'd1);
        tick();
        check("t2_stall3", 32'(bus.stall), 32'd0);
        tick();
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("t2_fwd_a", 32'(bus.forward_a), 32'd0);
`endif
        check("t2_add_alu_op", 32'(bus.ex_alu_op), 32'd2);

        // 3: ADD x5,x1,x2 then SUB x7,x5,x5
        do_reset();
        set_id(1'b1, OP_ARITH, 5'd1, 5'd2, 5'd5);
        tick();
        set_id(1'b1, OP_ARITH, 5'd5, 5'd5, 5'd7);
`ifdef FORWARDING_EN
        check("t3_stall", 32'(bus.stall), 32'd0);
        tick();
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("t3_fwd_a", 32'(bus.forward_a), 32'd2);
        check("t3_fwd_b", 32'(bus.forward_b), 32'd2);
`else
        check("t3_stall1", 32'(bus.stall), 32'd1);
        tick();
        check("t3_stall2", 32'(bus.stall), 32'd1);
        tick();
        check("t3_stall3", 32'(bus.stall), 32'd0);
        tick();
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("t3_fwd_ab", 32'({bus.forward_a, bus.forward_b}), 32'd0);
`endif
        check("t3_sub_alu_op", 32'(bus.ex_alu_op), 32'd2);

        // 4: LW x5; BEQ x0,x0 flushes while dependent ADD sits in ID
        do_reset();
        set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
        tick();
        set_id(1'b1, OP_BRANCH, 5'd0, 5'd0, 5'd0);
        check("t4_beq_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.ex_flush = 1'b1;
        set_id(1'b1, OP_ARITH, 5'd5, 5'd1, 5'd6);
        check("t4_flush_stall", 32'(bus.stall), 32'd0);
        check("t4_beq_alu_op", 32'(bus.ex_alu_op), 32'd1);
        tick();
        bus.ex_flush = 1'b0;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("t4_ex_ctrl_zero",
              32'({bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_op}), 32'd0);

        // 5: ECALL with halt_req, then valid ADDs
        do_reset();
        bus.halt_req = 1'b1;
        set_id(1'b1, OP_ECALL, 5'd0, 5'd0, 5'd0);
        check("t5_ecall_id_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.halt_req = 1'b0;
        set_id(1'b1, OP_ARITH, 5'd2, 5'd3, 5'd1);
        check("t5_stall_ex", 32'(bus.stall), 32'd1);
        check("t5_halted0", 32'(bus.halted), 32'd0);
        tick();
        check("t5_halted1", 32'(bus.halted), 32'd0);
        tick();
        check("t5_halted2", 32'(bus.halted), 32'd0);
        check("t5_wb_ecall", 32'(bus.wb_reg_write), 32'd0);
        tick();
        check("t5_halted3", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t5_add_no_wb", 32'(bus.wb_reg_write), 32'd0);
            check("t5_still_stall", 32'(bus.stall), 32'd1);
            tick();
        end
        check("t5_sticky", 32'(bus.halted), 32'd1);

        // Reset mid-operation clears the halt and all pipeline state
        reset = 1'b1;
        tick();
        check("midop_reset_outs", all_outs(), 32'd0);

        // 6: ADDI x0,x0,1 then ADD x1,x0,x0
        do_reset();
        set_id(1'b1, OP_ARITH_IMM, 5'd0, 5'd0, 5'd0);
        tick();
        set_id(1'b1, OP_ARITH, 5'd0, 5'd0, 5'd1);
        check("t6_stall", 32'(bus.stall), 32'd0);
        tick();
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        check("t6_fwd_ab", 32'({bus.forward_a, bus.forward_b}), 32'd0);
        tick();
        check("t6_addi_no_wb", 32'(bus.wb_reg_write), 32'd0);
        tick();
        check("t6_add_wb", 32'(bus.wb_reg_write), 32'd1);
        check("t6_add_wb_rd", 32'(bus.wb_rd), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
